// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and hold/flush
// control. Chooses one action per cycle (RUN, BUBBLE, HOLD, FLUSH), drives the
// front-end enables combinationally, and records the action and a saturating
// count of non-RUN cycles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_valid,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic [XLEN-1:0]  ID_rs1_data,
  input  logic [XLEN-1:0]  ID_rs2_data,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic             ID_regwrite,
  input  logic             ID_memread,
  input  logic             ID_memwrite,
  input  logic             ID_memtoreg,
  input  logic             ID_alusrc,
  input  logic [2:0]       ID_aluop,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             EX_valid,
  output logic [4:0]       EX_rs1,
  output logic [4:0]       EX_rs2,
  output logic [4:0]       EX_rd,
  output logic [XLEN-1:0]  EX_rs1_data,
  output logic [XLEN-1:0]  EX_rs2_data,
  output logic [XLEN-1:0]  EX_imm,
  output logic             EX_regwrite,
  output logic             EX_memread,
  output logic             EX_memwrite,
  output logic             EX_memtoreg,
  output logic             EX_alusrc,
  output logic [2:0]       EX_aluop,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2,
    ACT_FLUSH  = 2'd3
  } act_e;

  // All-zero value of this struct is the bubble: invalid, no control, index 0.
  typedef struct packed {
    logic            valid;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic [2:0]      aluop;
  } ex_t;

  ex_t             id_p0;
  ex_t             ex_d;
  ex_t             ex_p1;
  logic            lu_p0;
  act_e            act_p0;
  act_e            hz_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ---- stage p0: ID fields, hazard detection, action select ----
  assign id_p0 = '{valid:    ID_valid,
                   rs1:      ID_rs1,
                   rs2:      ID_rs2,
                   rd:       ID_rd,
                   rs1_data: ID_rs1_data,
                   rs2_data: ID_rs2_data,
                   imm:      ID_imm,
                   regwrite: ID_regwrite,
                   memread:  ID_memread,
                   memwrite: ID_memwrite,
                   memtoreg: ID_memtoreg,
                   alusrc:   ID_alusrc,
                   aluop:    ID_aluop};

  // Pick the action by priority and derive front-end enables and next EX contents.
  always_comb begin
    lu_p0      = ex_p1.valid & ex_p1.memread & (ex_p1.rd != 5'd0) & ID_valid &
                 ((ex_p1.rd == ID_rs1) | (ex_p1.rd == ID_rs2));
    act_p0     = ACT_RUN;
    PC_write   = 1'b1;
    IFID_write = 1'b1;
    IFID_flush = 1'b0;
    ex_d       = id_p0;
    if (mem_stall)         act_p0 = ACT_HOLD;
    else if (branch_taken) act_p0 = ACT_FLUSH;
    else if (lu_p0)        act_p0 = ACT_BUBBLE;
    case (act_p0)
      ACT_HOLD: begin
        PC_write   = 1'b0;
        IFID_write = 1'b0;
        ex_d       = ex_p1;
      end
      ACT_FLUSH: begin
        IFID_flush = 1'b1;
        ex_d       = '0;
      end
      ACT_BUBBLE: begin
        PC_write   = 1'b0;
        IFID_write = 1'b0;
        ex_d       = '0;
      end
      default: ;
    endcase
  end

  // ---- stage p1: ID/EX register ----
  // Load the selected next EX contents; reset clears to a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) ex_p1 <= '0;
    else       ex_p1 <= ex_d;
  end

  // Record the action taken and count every non-RUN edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hz_p1  <= ACT_RUN;
      cnt_p1 <= '0;
    end else begin
      hz_p1 <= act_p0;
      if (act_p0 != ACT_RUN) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign EX_valid     = ex_p1.valid;
  assign EX_rs1       = ex_p1.rs1;
  assign EX_rs2       = ex_p1.rs2;
  assign EX_rd        = ex_p1.rd;
  assign EX_rs1_data  = ex_p1.rs1_data;
  assign EX_rs2_data  = ex_p1.rs2_data;
  assign EX_imm       = ex_p1.imm;
  assign EX_regwrite  = ex_p1.regwrite;
  assign EX_memread   = ex_p1.memread;
  assign EX_memwrite  = ex_p1.memwrite;
  assign EX_memtoreg  = ex_p1.memtoreg;
  assign EX_alusrc    = ex_p1.alusrc;
  assign EX_aluop     = ex_p1.aluop;
  assign hz_state     = hz_p1;
  assign stall_cycles = cnt_p1;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register combined with load-use hazard detection and pipeline hold/flush control for the 5-stage RISC-V core. It captures decoded operands and control from ID and presents them to EX, where its `EX_rs1`, `EX_rs2` and `EX_rd` fields feed the forwarding unit and the operand muxes. It inserts bubbles on load-use hazards and flushes on taken branches. It freezes on data-memory wait and keeps a registered status plus a saturating stall counter.

## Interface
- `XLEN`, default 32: datapath width.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `ID_valid` in 1: ID holds a real instruction.
- `ID_rs1`, `ID_rs2`, `ID_rd` in 5: register indices.
- `ID_rs1_data`, `ID_rs2_data`, `ID_imm` in XLEN: operand data and immediate.
- `ID_regwrite`, `ID_memread`, `ID_memwrite`, `ID_memtoreg`, `ID_alusrc` in 1: control bits.
- `ID_aluop` in 3: ALU operation.
- `branch_taken` in 1: EX resolved a taken branch this cycle.
- `mem_stall` in 1: data memory not ready; whole pipeline must hold.
- `EX_valid`, `EX_rs1`, `EX_rs2`, `EX_rd`, `EX_rs1_data`, `EX_rs2_data`, `EX_imm`, `EX_regwrite`, `EX_memread`, `EX_memwrite`, `EX_memtoreg`, `EX_alusrc`, `EX_aluop` out: registered copies of the ID fields, same widths.
- `PC_write` out 1: PC may advance (combinational).
- `IFID_write` out 1: IF/ID may load (combinational).
- `IFID_flush` out 1: IF/ID must load a bubble (combinational).
- `hz_state` out 2: registered action taken at the last edge.
- `stall_cycles` out CNT_W: saturating count of non-RUN cycles.

## Operation
- Load-use hazard, combinational: `lu = EX_valid & EX_memread & (EX_rd != 0) & ID_valid & (EX_rd == ID_rs1 | EX_rd == ID_rs2)`.
- Action priority, highest first:
  1. `rst_i`.
  2. HOLD: `mem_stall`.
  3. FLUSH: `branch_taken`.
  4. BUBBLE: `lu`.
  5. RUN.
- HOLD:
  - All EX_* registers keep their value.
  - `PC_write=0`, `IFID_write=0`, `IFID_flush=0`.
- FLUSH:
  - The ID/EX register loads a bubble.
  - `PC_write=1`, `IFID_write=1`, `IFID_flush=1`.
- BUBBLE:
  - The ID/EX register loads a bubble.
  - `PC_write=0`, `IFID_write=0`, `IFID_flush=0`.
  - The ID instruction is re-presented next cycle.
- RUN:
  - The ID/EX register loads all ID fields; `EX_valid=ID_valid`.
  - `PC_write=1`, `IFID_write=1`, `IFID_flush=0`.
- Bubble contents: every EX_* output is 0, including `EX_valid`, all control bits, indices and data. Register index 0 never matches the forwarding unit's compares.
- `hz_state` encoding: RUN=0, BUBBLE=1, HOLD=2, FLUSH=3. It registers the action chosen in the cycle and updates every edge, including HOLD.
- `stall_cycles`:
  - Increments on every edge whose action is not RUN.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- An ID instruction with `ID_valid=0` never causes BUBBLE and loads as `EX_valid=0` in RUN.

## Timing
- Latency: ID fields appear on EX_* one cycle after the edge on which RUN is taken.
- Control outputs (`PC_write`, `IFID_write`, `IFID_flush`) are purely combinational from the current inputs and EX_* state, so they take effect in the same cycle.
- A load-use stalls exactly one cycle: after BUBBLE, `EX_memread=0`, so `lu=0` and the next action is RUN (absent other events).
- HOLD during a pending load-use:
  - `lu` stays asserted because EX is frozen.
  - After `mem_stall` drops, BUBBLE occurs on that cycle.
- `mem_stall` together with `branch_taken`: HOLD wins. EX is held, so the branch still sits in EX and re-asserts `branch_taken` after the hold.
- `branch_taken` together with `lu`: FLUSH wins, and the dependent instruction is discarded.
- Reset (including mid-hold or mid-bubble), at the next edge:
  - all EX_* outputs are 0;
  - `hz_state=0`;
  - `stall_cycles=0`.
- During reset, combinational outputs follow the rules above using the zeroed state: `PC_write=1`, `IFID_write=1`, `IFID_flush=0` unless `mem_stall` or `branch_taken` is asserted.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with random ID inputs. Required: all EX_*=0, `hz_state=0`, `stall_cycles=0`; then ID `rd=5, rs1=1` loads and appears on EX one cycle later.
- **Load-use:** `lw x5` in EX (`EX_memread=1`, `EX_rd=5`), ID `add rs2=5`.
  - Cycle 0: `PC_write=0`, `IFID_write=0`.
  - Next edge: `EX_valid=0`, `hz_state=1`, `stall_cycles=1`.
  - Following edge: the add loads with `EX_rs2=5`.
- **Load-use, no hazard:** load to `x0` (`EX_rd=0`) with ID `rs1=0`, and a separate case of load `rd=5` with ID `rs1=6, rs2=7`. Required: no stall in either case, `hz_state=0`.
- **Branch flush:** `branch_taken=1` for one cycle. Required: `IFID_flush=1` and `PC_write=1` that cycle; EX bubble next edge; `hz_state=3`.
- **Memory hold:** `mem_stall=1` for 3 cycles with a pending load-use. Required: EX_* unchanged for 3 edges, `hz_state=2`; then one BUBBLE, then RUN; `stall_cycles=4`.
- **Counter saturation:** with `CNT_W=4`, hold `mem_stall` for 20 cycles. Required: `stall_cycles` reaches 15 and stays at 15.
